// File: rtl/aes128_encrypt.sv
// aes128_encrypt
//   Iterative AES-128 encryptor (FIPS-197 cipher direction only). One round
//   per clock with on-the-fly round-key expansion; result after 10 cycles.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   request, accepted on a rising edge while busy=0
//   key         in   128-bit key, bits [127:120] = key byte 0
//   plaintext   in   128-bit block, bits [127:120] = state byte 0 (column-major)
//   ciphertext  out  registered result, held until the next completion
//   busy        out  block in flight (low during the final round, see below)
//   done        out  one-cycle pulse, ciphertext valid in the same cycle
module aes128_encrypt (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic         done
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    typedef enum logic {S_IDLE, S_ROUND} fsm_t;

    fsm_t         fsm;
    logic [3:0]   rnd;
    logic [127:0] blk;        // cipher state
    logic [127:0] rk;         // current round key
    logic [127:0] nk;         // next round key
    logic [127:0] round_out;
    logic [7:0]   rcon;
    logic         accept;
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];
    logic [31:0]  w0, w1, w2, w3, rotw, subw, n0, n1, n2, n3;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes, ShiftRows (row r rotates left by r), MixColumns, AddRoundKey
    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb[i] = SBOX[blk[127-8*i -: 8]];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[4*c+r] = sb[4*((c+r)%4)+r];
        end
        assign mc[4*c+0] = xt(sr[4*c+0]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+1] = sr[4*c+0] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
        assign mc[4*c+3] = xt(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
    end

    // the final round skips MixColumns; each round uses the key expanded this cycle
    for (genvar i = 0; i < 16; i++) begin : g_ark
        assign round_out[127-8*i -: 8] = ((rnd == 4'd10) ? sr[i] : mc[i]) ^ nk[127-8*i -: 8];
    end

    // key expansion for the round being computed
    assign w0   = rk[127:96];
    assign w1   = rk[95:64];
    assign w2   = rk[63:32];
    assign w3   = rk[31:0];
    assign rotw = {w3[23:0], w3[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_subword
        assign subw[31-8*j -: 8] = SBOX[rotw[31-8*j -: 8]];
    end

    always_comb begin
        rcon = 8'h00;
        case (rnd)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign n0 = w0 ^ subw ^ {rcon, 24'h000000};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign nk = {n0, n1, n2, n3};

    assign accept = start & ~busy;

    // busy drops one cycle early (while round 10 is computed) so that a start
    // can be taken on the completion edge, giving one block every 10 cycles.
    // A load on that edge overrides the round-register updates below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm        <= S_IDLE;
            rnd        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ciphertext <= '0;
            blk        <= '0;
            rk         <= '0;
        end else begin
            done <= 1'b0;
            if (fsm == S_ROUND) begin
                blk <= round_out;
                rk  <= nk;
                rnd <= rnd + 4'd1;
                if (rnd == 4'd9) begin
                    busy <= 1'b0;
                end
                if (rnd == 4'd10) begin
                    ciphertext <= round_out;
                    done       <= 1'b1;
                    fsm        <= S_IDLE;
                    rnd        <= '0;
                end
            end
            if (accept) begin
                blk  <= plaintext ^ key;
                rk   <= key;
                rnd  <= 4'd1;
                busy <= 1'b1;
                fsm  <= S_ROUND;
            end
        end
    end

endmodule

// File: tb/tb_aes128_encrypt.sv
// tb_aes128_encrypt
//   Self-checking bench for aes128_encrypt. The reference is a software
//   AES-128 whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes128_encrypt;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] plaintext = '0;
    logic [127:0] ciphertext;
    logic         busy;
    logic         done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] sbox_m [256];

    aes128_encrypt dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key        (key),
        .plaintext  (plaintext),
        .ciphertext (ciphertext),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(v));
            end
            sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*((c+rr)%4)+rr];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One block; poke=1 pulses start with fresh operands at edges 3 and 7
    task automatic run_block(input logic [127:0] k, input logic [127:0] p,
                             input logic [127:0] exp, input string tag, input bit poke);
        int lat;
        int ndone;
        logic [127:0] got;
        lat = 0; ndone = 0; got = '0;
        @(negedge clk);
        key = k; plaintext = p; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk);
            #1;
            start = poke && (c == 2 || c == 6);
            if (poke) begin
                key = rnd128();
                plaintext = rnd128();
            end
            @(negedge clk);
            if (c == 1) check({tag, "_busy"}, 128'(busy), 128'(1));
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = c;
                    got = ciphertext;
                end
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 128'(lat), 128'(10));
        check({tag, "_ct"}, got, exp);
        check({tag, "_ndone"}, 128'(ndone), 128'(1));
        check({tag, "_hold"}, ciphertext, exp);
    endtask

    initial begin : main
        logic [127:0] kc1, pc1, ec1, kcbc, iv, prev;
        logic [127:0] pb [4];
        logic [127:0] eb [4];
        int nst, nd, edges, cnt;
        int td [4];

        build_sbox();
        kc1 = 128'h000102030405060708090a0b0c0d0e0f;
        pc1 = 128'h00112233445566778899aabbccddeeff;
        ec1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ct", ciphertext, '0);
        check("rst_done", 128'(done), '0);
        check("rst_busy", 128'(busy), '0);

        // known-answer vectors; the model must agree with the published values
        check("model_c1", aes_ref(kc1, pc1), ec1);
        run_block(kc1, pc1, ec1, "c1", 1'b0);
        run_block(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32, "appb", 1'b0);
        run_block('0, '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, "zero", 1'b0);
        run_block(kc1, pc1, ec1, "ignore", 1'b1);

        // asynchronous reset mid-block
        @(negedge clk);
        key = kc1; plaintext = pc1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ct", ciphertext, '0);
        check("arst_done", 128'(done), '0);
        check("arst_busy", 128'(busy), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("arst_nodone", 128'(cnt), '0);

        // CBC chain driven from the bench, starts offered whenever busy is low
        kcbc = 128'h0f1571c947d9e8590cb7add6af7f6798;
        iv   = 128'h5468617473206d79204b756e67204675;
        prev = iv;
        for (int i = 0; i < 4; i++) begin
            pb[i] = rnd128();
            eb[i] = aes_ref(kcbc, pb[i] ^ prev);
            prev  = eb[i];
        end
        nst = 0; nd = 0; edges = 0;
        @(negedge clk);
        while (nd < 4 && edges < 200) begin
            if (!busy && nst < 4) begin
                key = kcbc;
                plaintext = pb[nst] ^ ((nst == 0) ? iv : eb[nst-1]);
                start = 1'b1;
                nst++;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) begin
                check($sformatf("cbc_ct%0d", nd), ciphertext, eb[nd]);
                td[nd] = edges;
                nd++;
            end
        end
        start = 1'b0;
        check("cbc_count", 128'(nd), 128'(4));
        for (int i = 1; i < 4; i++) begin
            if (i < nd) check($sformatf("cbc_gap%0d", i), 128'(td[i] - td[i-1]), 128'(10));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
